conv_mac_ctrl: RTL and testbench
================================

CONV_MAC_CTRL -- requirements
Module: conv_mac_ctrl

Interface
REQ-001 Parameter K, default 3, filter edge length (filter is K x K).
REQ-002 Parameter IMG_ROWS, default 4, image row count.
REQ-003 Parameter IMG_COLS, default 4, image column count.
REQ-004 Parameter ADDR_W, default 8, width of all address outputs.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request to convolve the full image; sampled in IDLE only.
REQ-008 out_ready  input  1  consumer accepts the current result when high with out_valid.
REQ-009 img_addr  output  ADDR_W  image memory read address (1-cycle synchronous read).
REQ-010 filt_addr  output  ADDR_W  filter memory read address (1-cycle synchronous read).
REQ-011 acc_rst  output  1  clears the MAC accumulator.
REQ-012 acc_en  output  1  enables MAC accumulation of the current pixel/filter pair.
REQ-013 out_valid  output  1  MAC output holds a finished window result.
REQ-014 out_addr  output  ADDR_W  result index, row-major over the output map.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after the last result is accepted.

Function
REQ-017 Output map SHALL be OUT_ROWS = IMG_ROWS-K+1 by OUT_COLS = IMG_COLS-K+1; windows visited row-major.
REQ-018 FSM states SHALL be IDLE, CLEAR, ACCUM, DRAIN, WRITE, DONE.
REQ-019 IDLE -> CLEAR when start=1; otherwise remain.
REQ-020 CLEAR: one cycle, acc_rst=1, window counters (i,j) set to 0; -> ACCUM.
REQ-021 ACCUM: K*K cycles; each cycle img_addr = (row+i)*IMG_COLS + (col+j), filt_addr = i*K + j; j wraps K-1 -> 0 with i incrementing; after i=K-1,j=K-1 -> DRAIN.
REQ-022 acc_en SHALL be the ACCUM-valid flag delayed by exactly one cycle, so it is high in the K*K cycles following each issued address (last one falls in DRAIN).
REQ-023 DRAIN: one cycle, no address issued; -> WRITE.
REQ-024 WRITE: out_valid=1, out_addr = row*OUT_COLS + col; out_valid and out_addr held stable until out_ready=1; acc_en=0 and acc_rst=0 throughout.
REQ-025 On WRITE with out_ready=1: if col=OUT_COLS-1 then col wraps to 0 and row increments, else col increments; -> CLEAR, or -> DONE if that was row=OUT_ROWS-1, col=OUT_COLS-1.
REQ-026 DONE: done=1 for exactly one cycle; -> IDLE; row/col cleared.
REQ-027 start while busy=1 SHALL be ignored, including start in DONE.
REQ-028 Per-window latency with out_ready held high SHALL be K*K+3 cycles (CLEAR + K*K + DRAIN + WRITE).
REQ-029 img_addr and filt_addr SHALL be 0 outside ACCUM; out_addr SHALL be 0 outside WRITE.
REQ-030 All address arithmetic SHALL be unsigned and computed at ADDR_W bits; IMG_ROWS*IMG_COLS and K*K SHALL not exceed 2**ADDR_W (elaboration-time check).

Reset
REQ-031 rst=1 SHALL immediately force IDLE, all counters 0, and every output 0, regardless of state, including mid-ACCUM or mid-WRITE.
REQ-032 After rst deasserts, operation SHALL restart only on a new start, beginning at out_addr 0.

Structure
REQ-033 Package conv_pkg SHALL hold the FSM state enum typedef and default values for K, IMG_ROWS, IMG_COLS, ADDR_W.
REQ-034 Sub-module window_counter SHALL implement a two-level wrapping counter (inner/outer with enable, clear, wrap flag); instantiated twice: (i,j) and (row,col).

Verification (K=3, IMG 4x4, ADDR_W=8; start sampled at edge 0)
REQ-035 Reset: assert rst mid-run -> all outputs 0 same cycle; busy=0; state IDLE.
REQ-036 start=1, out_ready=1: acc_rst=1 in cycle 1; img_addr 0,1,2,4,5,6,8,9,10 and filt_addr 0..8 in cycles 2-10; acc_en=1 cycles 3-11; out_valid with out_addr=0 in cycle 12.
REQ-037 Window order: window 2 img_addr starts at 1, window 3 at 4, window 4 at 5; out_addr 1,2,3 in cycles 24,36,48; done=1 in cycle 49, busy=0 in cycle 50.
REQ-038 Backpressure: out_ready=0 for 5 cycles in first WRITE -> out_valid=1, out_addr=0 held 6 cycles, acc_en=0, no address change; next CLEAR follows acceptance.
REQ-039 start pulsed in cycles 5 and 49 -> ignored; no restart, out_addr sequence unchanged.
REQ-040 rst in cycle 7 (ACCUM), released cycle 9, start cycle 12 -> sequence identical to REQ-036 offset by 12 cycles.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution MAC controller.
package conv_pkg;

  localparam int K_DEF        = 3;
  localparam int IMG_ROWS_DEF = 4;
  localparam int IMG_COLS_DEF = 4;
  localparam int ADDR_W_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/window_counter.sv
// Two-level wrapping counter (outer/inner) that exposes its next-state values and a last-position flag.
module window_counter
  import conv_pkg::*;
#(
  parameter int W         = ADDR_W_DEF,
  parameter int INNER_MAX = 2,
  parameter int OUTER_MAX = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] inner_nxt_o,
  output logic [W-1:0] outer_nxt_o,
  output logic         wrap_o
);

  logic [W-1:0] inner_q, inner_d;
  logic [W-1:0] outer_q, outer_d;
  logic         inner_last, outer_last;

  assign inner_last = (inner_q == W'(INNER_MAX));
  assign outer_last = (outer_q == W'(OUTER_MAX));
  assign wrap_o     = inner_last && outer_last;

  always_comb begin
    inner_d = inner_q;
    outer_d = outer_q;
    if (clr_i) begin
      inner_d = '0;
      outer_d = '0;
    end else if (en_i) begin
      if (inner_last) begin
        inner_d = '0;
        outer_d = outer_last ? '0 : outer_q + W'(1);
      end else begin
        inner_d = inner_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inner_q <= '0;
      outer_q <= '0;
    end else begin
      inner_q <= inner_d;
      outer_q <= outer_d;
    end
  end

  assign inner_nxt_o = inner_d;
  assign outer_nxt_o = outer_d;

endmodule

// File: rtl/conv_mac_ctrl.sv
// Sequences image/filter reads for a K x K convolution over the full image, one window at a time,
// and hands each finished accumulator result to a ready/valid consumer.
module conv_mac_ctrl
  import conv_pkg::*;
#(
  parameter int K        = K_DEF,
  parameter int IMG_ROWS = IMG_ROWS_DEF,
  parameter int IMG_COLS = IMG_COLS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] img_addr,
  output logic [ADDR_W-1:0] filt_addr,
  output logic              acc_rst,
  output logic              acc_en,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  localparam int OUT_ROWS = IMG_ROWS - K + 1;
  localparam int OUT_COLS = IMG_COLS - K + 1;

  if (longint'(IMG_ROWS) * longint'(IMG_COLS) > (longint'(1) << ADDR_W)) begin : g_img_fit_chk
    $error("IMG_ROWS*IMG_COLS does not fit in ADDR_W address bits");
  end
  if (longint'(K) * longint'(K) > (longint'(1) << ADDR_W)) begin : g_filt_fit_chk
    $error("K*K does not fit in ADDR_W address bits");
  end
  if (K < 1 || K > IMG_ROWS || K > IMG_COLS) begin : g_geom_chk
    $error("filter edge K must be between 1 and the image dimensions");
  end

  function automatic logic [ADDR_W-1:0] img_addr_f(input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] c,
                                                   input logic [ADDR_W-1:0] i, input logic [ADDR_W-1:0] j);
    return (r + i) * ADDR_W'(IMG_COLS) + (c + j);
  endfunction

  function automatic logic [ADDR_W-1:0] filt_addr_f(input logic [ADDR_W-1:0] i, input logic [ADDR_W-1:0] j);
    return i * ADDR_W'(K) + j;
  endfunction

  function automatic logic [ADDR_W-1:0] out_addr_f(input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] c);
    return r * ADDR_W'(OUT_COLS) + c;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] i_nxt, j_nxt, row_nxt, col_nxt;
  logic              tap_wrap, win_wrap;
  logic              tap_clr, tap_en, win_clr, win_en;

  logic [ADDR_W-1:0] img_addr_q, filt_addr_q, out_addr_q;
  logic              acc_rst_q, acc_en_q, out_valid_q, busy_q, done_q;

  assign tap_clr = (state_q == CLEAR);
  assign tap_en  = (state_q == ACCUM);
  assign win_clr = (state_q == DONE);
  assign win_en  = (state_q == WRITE) && out_ready;

  window_counter #(
    .W        (ADDR_W),
    .INNER_MAX(K - 1),
    .OUTER_MAX(K - 1)
  ) u_tap_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (tap_clr),
    .en_i       (tap_en),
    .inner_nxt_o(j_nxt),
    .outer_nxt_o(i_nxt),
    .wrap_o     (tap_wrap)
  );

  window_counter #(
    .W        (ADDR_W),
    .INNER_MAX(OUT_COLS - 1),
    .OUTER_MAX(OUT_ROWS - 1)
  ) u_win_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (win_clr),
    .en_i       (win_en),
    .inner_nxt_o(col_nxt),
    .outer_nxt_o(row_nxt),
    .wrap_o     (win_wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = ACCUM;
      ACCUM:   if (tap_wrap) state_d = DRAIN;
      DRAIN:   state_d = WRITE;
      WRITE:   if (out_ready) state_d = win_wrap ? DONE : CLEAR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state and next counter values so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      img_addr_q  <= '0;
      filt_addr_q <= '0;
      out_addr_q  <= '0;
      acc_rst_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      img_addr_q  <= (state_d == ACCUM) ? img_addr_f(row_nxt, col_nxt, i_nxt, j_nxt) : '0;
      filt_addr_q <= (state_d == ACCUM) ? filt_addr_f(i_nxt, j_nxt) : '0;
      out_addr_q  <= (state_d == WRITE) ? out_addr_f(row_nxt, col_nxt) : '0;
      acc_rst_q   <= (state_d == CLEAR);
      acc_en_q    <= (state_q == ACCUM);
      out_valid_q <= (state_d == WRITE);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
    end
  end

  assign img_addr  = img_addr_q;
  assign filt_addr = filt_addr_q;
  assign out_addr  = out_addr_q;
  assign acc_rst   = acc_rst_q;
  assign acc_en    = acc_en_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// Directed bench for conv_mac_ctrl with K=3 over a 4x4 image (2x2 output map).
module tb_conv_mac_ctrl;

  typedef struct packed {
    logic [7:0] img;
    logic [7:0] filt;
    logic [7:0] oaddr;
    logic       acc_rst;
    logic       acc_en;
    logic       ov;
    logic       busy;
    logic       done;
  } obs_t;

  localparam int TAP_OFF [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  localparam int W_BASE  [4] = '{0, 1, 4, 5};

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       out_ready;
  logic [7:0] img_addr;
  logic [7:0] filt_addr;
  logic [7:0] out_addr;
  logic       acc_rst;
  logic       acc_en;
  logic       out_valid;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  conv_mac_ctrl #(
    .K       (3),
    .IMG_ROWS(4),
    .IMG_COLS(4),
    .ADDR_W  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .out_ready(out_ready),
    .img_addr (img_addr),
    .filt_addr(filt_addr),
    .acc_rst  (acc_rst),
    .acc_en   (acc_en),
    .out_valid(out_valid),
    .out_addr (out_addr),
    .busy     (busy),
    .done     (done)
  );

  // Expected outputs in cycle c after start was sampled (c=1 is CLEAR of window 0);
  // stall extends the first WRITE by that many not-ready cycles.
  function automatic obs_t model(input int c, input int stall);
    obs_t e;
    int   t;
    int   len;
    e = '0;
    t = c;
    if (c < 1) return e;
    for (int w = 0; w < 4; w++) begin
      len = 12 + ((w == 0) ? stall : 0);
      if (t <= len) begin
        e.busy = 1'b1;
        if (t == 1) e.acc_rst = 1'b1;
        if (t >= 2 && t <= 10) begin
          e.img  = 8'(W_BASE[w] + TAP_OFF[t-2]);
          e.filt = 8'(t - 2);
        end
        if (t >= 3 && t <= 11) e.acc_en = 1'b1;
        if (t >= 12) begin
          e.ov    = 1'b1;
          e.oaddr = 8'(w);
        end
        return e;
      end
      t -= len;
    end
    if (t == 1) begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.img     = img_addr;
    o.filt    = filt_addr;
    o.oaddr   = out_addr;
    o.acc_rst = acc_rst;
    o.acc_en  = acc_en;
    o.ov      = out_valid;
    o.busy    = busy;
    o.done    = done;
    return o;
  endfunction

  function automatic string fmt(input obs_t v);
    return $sformatf("img=%0d filt=%0d oaddr=%0d acc_rst=%0b acc_en=%0b out_valid=%0b busy=%0b done=%0b",
                     v.img, v.filt, v.oaddr, v.acc_rst, v.acc_en, v.ov, v.busy, v.done);
  endfunction

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    o = sample();
    n_checks++;
    if (o !== obs_t'('0)) $display("FAIL reset_hold: got %s, required all zero", fmt(o));
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    o = sample();
    n_checks++;
    if (o !== obs_t'('0)) $display("FAIL reset_idle: got %s, required all zero", fmt(o));
    else n_pass++;
  endtask

  task automatic test_full_run();
    obs_t o, e;
    start = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      @(posedge clk);
      @(negedge clk);
      o = sample();
      e = model(c, 0);
      n_checks++;
      if (o !== e) $display("FAIL full_run cycle %0d: got %s, required %s", c, fmt(o), fmt(e));
      else n_pass++;
      start = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  task automatic test_backpressure();
    obs_t o, e;
    start = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 57; c++) begin
      @(posedge clk);
      @(negedge clk);
      o = sample();
      e = model(c, 5);
      n_checks++;
      if (o !== e) $display("FAIL backpressure cycle %0d: got %s, required %s", c, fmt(o), fmt(e));
      else n_pass++;
      start = 1'b0;
      out_ready = !(c >= 12 && c < 17);
    end
  endtask

  task automatic test_start_ignored();
    obs_t o, e;
    start = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 54; c++) begin
      @(posedge clk);
      @(negedge clk);
      o = sample();
      e = model(c, 0);
      n_checks++;
      if (o !== e) $display("FAIL start_ignored cycle %0d: got %s, required %s", c, fmt(o), fmt(e));
      else n_pass++;
      start = (c == 5) || (c == 49);
      out_ready = 1'b1;
    end
  endtask

  task automatic test_reset_mid_write();
    obs_t o, e;
    start = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #1;
      if (c == 14) begin
        rst = 1'b1;
        #1;
        o = sample();
        n_checks++;
        if (o !== obs_t'('0)) $display("FAIL rst_mid_write_async: got %s, required all zero", fmt(o));
        else n_pass++;
      end
      @(negedge clk);
      o = sample();
      e = (c == 14) ? obs_t'('0) : model(c, 10);
      n_checks++;
      if (o !== e) $display("FAIL rst_mid_write cycle %0d: got %s, required %s", c, fmt(o), fmt(e));
      else n_pass++;
      start = 1'b0;
      out_ready = !(c >= 12);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    o = sample();
    n_checks++;
    if (o !== obs_t'('0)) $display("FAIL rst_mid_write_idle: got %s, required all zero", fmt(o));
    else n_pass++;
  endtask

  task automatic test_reset_restart();
    obs_t o, e;
    start = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 62; c++) begin
      @(posedge clk);
      #1;
      if (c == 7) begin
        rst = 1'b1;
        #1;
        o = sample();
        n_checks++;
        if (o !== obs_t'('0)) $display("FAIL rst_mid_accum_async: got %s, required all zero", fmt(o));
        else n_pass++;
      end
      if (c == 9) rst = 1'b0;
      @(negedge clk);
      o = sample();
      if (c < 7) e = model(c, 0);
      else if (c <= 12) e = '0;
      else e = model(c - 12, 0);
      n_checks++;
      if (o !== e) $display("FAIL reset_restart cycle %0d: got %s, required %s", c, fmt(o), fmt(e));
      else n_pass++;
      start = (c == 12);
      out_ready = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_write();
    test_reset_restart();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
